// File: rtl/cpu_top.sv
// Multicycle 16-bit RISC core: FETCH -> EXEC [-> MEM] over separate
// Wishbone-style instruction and data master ports.

module cpu_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [3:0]  waddr,
    input  logic [15:0] wdata,
    input  logic [3:0]  ra_addr,
    input  logic [3:0]  rb_addr,
    input  logic [3:0]  rd_addr,
    output logic [15:0] ra_data,
    output logic [15:0] rb_data,
    output logic [15:0] rd_data
);
    localparam logic [3:0] ZERO_REG = 4'd12;

    logic [15:0] rf [0:15];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 16; i++) begin
                rf[i] <= '0;
            end
        end else if (we && (waddr != ZERO_REG)) begin
            rf[waddr] <= wdata;
        end
    end

    assign ra_data = (ra_addr == ZERO_REG) ? '0 : rf[ra_addr];
    assign rb_data = (rb_addr == ZERO_REG) ? '0 : rf[rb_addr];
    assign rd_data = (rd_addr == ZERO_REG) ? '0 : rf[rd_addr];
endmodule

module cpu_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] instr_addr_o,
    input  logic [15:0] instr_data_i,
    output logic        instr_stb_o,
    input  logic        instr_ack_i,
    output logic [15:0] data_addr_o,
    output logic [15:0] data_data_o,
    input  logic [15:0] data_data_i,
    output logic        data_stb_o,
    output logic        data_we_o,
    input  logic        data_ack_i,
    output logic [3:0]  ra_addr,
    output logic [3:0]  rb_addr,
    output logic [3:0]  rd_addr,
    input  logic [15:0] ra_val,
    input  logic [15:0] rb_val,
    input  logic [15:0] rd_val,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [15:0] rf_wdata
);
    typedef enum logic [1:0] {FETCH, EXEC, MEM} state_e;

    typedef enum logic [3:0] {
        OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
        OP_XOR = 4'h4, OP_SHL = 4'h5, OP_SHR = 4'h6, OP_MUL = 4'h7,
        OP_LI  = 4'h8, OP_LUI = 4'h9, OP_LD  = 4'hA, OP_ST  = 4'hB,
        OP_BEQ = 4'hC, OP_BNE = 4'hD, OP_JAL = 4'hE, OP_JR  = 4'hF
    } op_e;

    localparam logic [3:0] LINK_REG = 4'd11;

    state_e      state;
    logic [15:0] pc;
    logic [15:0] pc_1;
    logic [15:0] ir;

    op_e         op;
    logic [15:0] sext4;
    logic [15:0] sext8;
    logic [15:0] sext12;
    logic [15:0] pc_inc;
    logic [15:0] alu;
    logic [15:0] next_pc;
    logic        is_mem;

    assign op      = op_e'(ir[15:12]);
    assign rd_addr = ir[11:8];
    assign ra_addr = ir[7:4];
    assign rb_addr = ir[3:0];
    assign sext4   = {{12{ir[3]}}, ir[3:0]};
    assign sext8   = {{8{ir[7]}}, ir[7:0]};
    assign sext12  = {{4{ir[11]}}, ir[11:0]};
    // pc_1 holds the executing instruction's address; relative targets use it.
    assign pc_inc  = pc_1 + 16'd1;
    assign is_mem  = (op == OP_LD) || (op == OP_ST);

    always_comb begin
        alu = '0;
        case (op)
            OP_ADD:  alu = ra_val + rb_val;
            OP_SUB:  alu = ra_val - rb_val;
            OP_AND:  alu = ra_val & rb_val;
            OP_OR:   alu = ra_val | rb_val;
            OP_XOR:  alu = ra_val ^ rb_val;
            OP_SHL:  alu = ra_val << rb_val[3:0];
            OP_SHR:  alu = ra_val >> rb_val[3:0];
            OP_MUL:  alu = ra_val * rb_val;
            OP_LI:   alu = sext8;
            OP_LUI:  alu = {ir[7:0], rd_val[7:0]};
            default: alu = '0;
        endcase
    end

    always_comb begin
        next_pc = pc_inc;
        case (op)
            OP_BEQ:  if (rd_val == ra_val) next_pc = pc_inc + sext4;
            OP_BNE:  if (rd_val != ra_val) next_pc = pc_inc + sext4;
            OP_JAL:  next_pc = pc_inc + sext12;
            OP_JR:   next_pc = ra_val;
            default: next_pc = pc_inc;
        endcase
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = rd_addr;
        rf_wdata = alu;
        if (state == EXEC) begin
            case (op)
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR,
                OP_MUL, OP_LI, OP_LUI: rf_we = 1'b1;
                OP_JAL: begin
                    rf_we    = 1'b1;
                    rf_waddr = LINK_REG;
                    rf_wdata = pc_inc;
                end
                default: rf_we = 1'b0;
            endcase
        end else if ((state == MEM) && data_stb_o && data_ack_i && (op == OP_LD)) begin
            rf_we    = 1'b1;
            rf_wdata = data_data_i;
        end
    end

    // Leaving EXEC/MEM raises the next fetch strobe directly, giving 2/3 cycles per instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= FETCH;
            pc           <= RESET_PC;
            pc_1         <= RESET_PC;
            ir           <= '0;
            instr_addr_o <= '0;
            instr_stb_o  <= 1'b0;
            data_addr_o  <= '0;
            data_data_o  <= '0;
            data_stb_o   <= 1'b0;
            data_we_o    <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (!instr_stb_o) begin
                        instr_stb_o  <= 1'b1;
                        instr_addr_o <= pc;
                    end else if (instr_ack_i) begin
                        ir          <= instr_data_i;
                        pc_1        <= pc;
                        instr_stb_o <= 1'b0;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    if (is_mem) begin
                        data_addr_o <= ra_val + sext4;
                        data_we_o   <= (op == OP_ST);
                        data_data_o <= rd_val;
                        data_stb_o  <= 1'b1;
                        state       <= MEM;
                    end else begin
                        pc           <= next_pc;
                        instr_addr_o <= next_pc;
                        instr_stb_o  <= 1'b1;
                        state        <= FETCH;
                    end
                end
                MEM: begin
                    if (data_stb_o && data_ack_i) begin
                        data_stb_o   <= 1'b0;
                        data_we_o    <= 1'b0;
                        pc           <= pc_inc;
                        instr_addr_o <= pc_inc;
                        instr_stb_o  <= 1'b1;
                        state        <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end
endmodule

module cpu_top #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    output logic [15:0] instr_addr_o,
    input  logic [15:0] instr_data_i,
    output logic        instr_stb_o,
    output logic        instr_we_o,
    input  logic        instr_ack_i,
    output logic [15:0] data_addr_o,
    output logic [15:0] data_data_o,
    input  logic [15:0] data_data_i,
    output logic        data_stb_o,
    output logic        data_we_o,
    input  logic        data_ack_i
);
    logic [3:0]  ra_addr;
    logic [3:0]  rb_addr;
    logic [3:0]  rd_addr;
    logic [15:0] ra_val;
    logic [15:0] rb_val;
    logic [15:0] rd_val;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;

    assign instr_we_o = 1'b0;

    cpu_unit #(.RESET_PC(RESET_PC)) unit (
        .clk          (sys_clk),
        .rst_n        (sys_rst),
        .instr_addr_o (instr_addr_o),
        .instr_data_i (instr_data_i),
        .instr_stb_o  (instr_stb_o),
        .instr_ack_i  (instr_ack_i),
        .data_addr_o  (data_addr_o),
        .data_data_o  (data_data_o),
        .data_data_i  (data_data_i),
        .data_stb_o   (data_stb_o),
        .data_we_o    (data_we_o),
        .data_ack_i   (data_ack_i),
        .ra_addr      (ra_addr),
        .rb_addr      (rb_addr),
        .rd_addr      (rd_addr),
        .ra_val       (ra_val),
        .rb_val       (rb_val),
        .rd_val       (rd_val),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata)
    );

    cpu_regfile u_rf (
        .clk     (sys_clk),
        .rst_n   (sys_rst),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .ra_addr (ra_addr),
        .rb_addr (rb_addr),
        .rd_addr (rd_addr),
        .ra_data (ra_val),
        .rb_data (rb_val),
        .rd_data (rd_val)
    );
endmodule

// File: tb/tb_cpu_top.sv
// Bench for cpu_top: bus responders with configurable wait states and an
// instruction-level reference model checked at every instruction fetch.

module tb_cpu_top;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        sys_clk;
    logic        sys_rst;
    logic [15:0] instr_addr_o;
    logic [15:0] instr_data_i;
    logic        instr_stb_o;
    logic        instr_we_o;
    logic        instr_ack_i;
    logic [15:0] data_addr_o;
    logic [15:0] data_data_o;
    logic [15:0] data_data_i;
    logic        data_stb_o;
    logic        data_we_o;
    logic        data_ack_i;

    cpu_top #(.RESET_PC(RESET_PC)) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .instr_addr_o (instr_addr_o),
        .instr_data_i (instr_data_i),
        .instr_stb_o  (instr_stb_o),
        .instr_we_o   (instr_we_o),
        .instr_ack_i  (instr_ack_i),
        .data_addr_o  (data_addr_o),
        .data_data_o  (data_data_o),
        .data_data_i  (data_data_i),
        .data_stb_o   (data_stb_o),
        .data_we_o    (data_we_o),
        .data_ack_i   (data_ack_i)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    typedef struct packed {
        logic [15:0] addr;
        logic        we;
        logic [15:0] data;
    } acc_t;

    logic [15:0] imem  [0:65535];
    logic [15:0] dmem  [0:65535];
    logic [15:0] mdmem [0:65535];
    logic [15:0] mreg  [0:15];
    logic [15:0] mpc;
    acc_t        exp_q [$];
    logic [15:0] fetch_log [$];

    int unsigned n_checks, n_pass;
    int unsigned cyc, last_fetch_cyc, fetch_cnt;
    int unsigned imode, dmode, iwait, dwait;
    bit          resp_en, lat_chk, have_prev, prev_mem;
    bit          ihold_v, dhold_v;
    logic [15:0] prev_addr, ihold_a;
    acc_t        dhold, dexp;
    logic [15:0] st_addr, st_data;
    int unsigned st_cnt;

    logic [15:0] exp_seq [0:24] = '{
        16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9,
        16'd10, 16'd13, 16'd14, 16'd15, 16'd16, 16'd17, 16'd18, 16'd19, 16'd20,
        16'd26, 16'd22, 16'd21, 16'd29, 16'hFFFE, 16'd40
    };

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    initial begin
        cyc = 0;
        forever @(posedge sys_clk) cyc++;
    end

    function automatic int unsigned next_wait(input int unsigned mode);
        case (mode)
            0:       return 0;
            1:       return 3;
            2:       return $urandom_range(0, 3);
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Reference model: ISA semantics in plain integer arithmetic.
    function automatic int sx(input int v, input int bits);
        return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
    endfunction

    function automatic logic [15:0] mget(input logic [3:0] r);
        return (r == 4'd12) ? 16'h0000 : mreg[r];
    endfunction

    task automatic mset(input logic [3:0] r, input logic [15:0] v);
        if (r != 4'd12) mreg[r] = v;
    endtask

    task automatic model_step;
        logic [15:0] ins, a, b, d, ea, nxt;
        logic [3:0]  op, rd, ra, rb;
        acc_t        acc;
        int          off4;
        ins  = imem[mpc];
        op   = ins[15:12];
        rd   = ins[11:8];
        ra   = ins[7:4];
        rb   = ins[3:0];
        a    = mget(ra);
        b    = mget(rb);
        d    = mget(rd);
        off4 = sx(int'(ins[3:0]), 4);
        ea   = 16'(int'(a) + off4);
        nxt  = 16'(int'(mpc) + 1);
        case (op)
            4'h0: mset(rd, 16'(int'(a) + int'(b)));
            4'h1: mset(rd, 16'(int'(a) - int'(b)));
            4'h2: mset(rd, a & b);
            4'h3: mset(rd, a | b);
            4'h4: mset(rd, a ^ b);
            4'h5: mset(rd, a << b[3:0]);
            4'h6: mset(rd, a >> b[3:0]);
            4'h7: mset(rd, 16'(longint'(a) * longint'(b)));
            4'h8: mset(rd, 16'(sx(int'(ins[7:0]), 8)));
            4'h9: mset(rd, 16'(int'(ins[7:0]) * 256 + int'(d % 16'd256)));
            4'hA: begin
                acc = '{addr: ea, we: 1'b0, data: 16'h0};
                exp_q.push_back(acc);
                mset(rd, mdmem[ea]);
            end
            4'hB: begin
                acc = '{addr: ea, we: 1'b1, data: d};
                exp_q.push_back(acc);
                mdmem[ea] = d;
            end
            4'hC: if (d == a) nxt = 16'(int'(mpc) + 1 + off4);
            4'hD: if (d != a) nxt = 16'(int'(mpc) + 1 + off4);
            4'hE: begin
                mset(4'd11, nxt);
                nxt = 16'(int'(mpc) + 1 + sx(int'(ins[11:0]), 12));
            end
            default: nxt = a;
        endcase
        mpc = nxt;
    endtask

    task automatic init_model;
        mpc = RESET_PC;
        for (int i = 0; i < 16; i++) mreg[i] = 16'h0;
        for (int i = 0; i < 65536; i++) mdmem[i] = dmem[i];
        exp_q.delete();
        fetch_log.delete();
        fetch_cnt = 0;
        have_prev = 0;
        ihold_v   = 0;
        dhold_v   = 0;
        st_cnt    = 0;
        iwait     = next_wait(imode);
        dwait     = next_wait(dmode);
    endtask

    // Called when a fetch ack is issued: the previous instruction has fully retired.
    task automatic on_fetch(input logic [15:0] addr);
        logic [3:0] op;
        chk("fetch_pc", addr, mpc);
        for (int i = 0; i < 16; i++)
            chk($sformatf("rf[%0d]", i), dut.u_rf.rf[i], mreg[i]);
        if (have_prev) begin
            chk("pc_1", dut.unit.pc_1, prev_addr);
            if (lat_chk) chk("latency", cyc - last_fetch_cyc, prev_mem ? 3 : 2);
        end
        op             = imem[mpc][15:12];
        prev_mem       = (op == 4'hA) || (op == 4'hB);
        have_prev      = 1;
        prev_addr      = addr;
        last_fetch_cyc = cyc;
        fetch_log.push_back(addr);
        fetch_cnt++;
        model_step();
    endtask

    initial begin
        forever begin
            @(negedge sys_clk);
            if (resp_en) begin
                if (instr_ack_i) begin
                    instr_ack_i = 1'b0;
                    iwait = next_wait(imode);
                end else if (instr_stb_o) begin
                    if (ihold_v) chk("istb_hold_addr", instr_addr_o, ihold_a);
                    else begin
                        ihold_v = 1;
                        ihold_a = instr_addr_o;
                    end
                    if (iwait == 0) begin
                        instr_data_i = imem[instr_addr_o];
                        instr_ack_i  = 1'b1;
                        ihold_v      = 0;
                        on_fetch(instr_addr_o);
                    end else iwait--;
                end else if (ihold_v) chk("istb_held", instr_stb_o, 1);

                if (data_ack_i) begin
                    data_ack_i = 1'b0;
                    dwait = next_wait(dmode);
                end else if (data_stb_o) begin
                    if (dhold_v) begin
                        chk("dstb_hold_addr", data_addr_o, dhold.addr);
                        chk("dstb_hold_we", data_we_o, dhold.we);
                        chk("dstb_hold_data", data_data_o, dhold.data);
                    end else begin
                        dhold_v = 1;
                        dhold   = '{addr: data_addr_o, we: data_we_o, data: data_data_o};
                    end
                    if (dwait == 0) begin
                        if (exp_q.size() == 0) chk("data_access_expected", exp_q.size(), 1);
                        else begin
                            dexp = exp_q.pop_front();
                            chk("data_addr", data_addr_o, dexp.addr);
                            chk("data_we", data_we_o, dexp.we);
                            if (dexp.we) chk("data_wdata", data_data_o, dexp.data);
                        end
                        if (data_we_o) begin
                            dmem[data_addr_o] = data_data_o;
                            st_addr = data_addr_o;
                            st_data = data_data_o;
                            st_cnt++;
                        end else data_data_i = dmem[data_addr_o];
                        data_ack_i = 1'b1;
                        dhold_v    = 0;
                    end else dwait--;
                end else if (dhold_v) chk("dstb_held", data_stb_o, 1);
            end
        end
    end

    task automatic do_reset;
        resp_en     = 0;
        sys_rst     = 1'b0;
        instr_ack_i = 1'b0;
        data_ack_i  = 1'b0;
        init_model();
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b1;
        resp_en = 1;
    endtask

    task automatic wait_fetches(input int unsigned n, input int unsigned budget);
        int unsigned t = 0;
        while (fetch_cnt < n && t < budget) begin
            @(posedge sys_clk);
            t++;
        end
        chk("fetch_budget", 32'(fetch_cnt >= n), 1);
    endtask

    task automatic load_directed;
        for (int i = 0; i < 65536; i++) begin
            imem[i] = 16'h0CCC;
            dmem[i] = 16'h0000;
        end
        imem[0]  = 16'h8005;  imem[1]  = 16'h81FD;  imem[2]  = 16'h0201;
        imem[3]  = 16'h1301;  imem[4]  = 16'h7400;  imem[5]  = 16'h5500;
        imem[6]  = 16'h8C07;  imem[7]  = 16'h8634;  imem[8]  = 16'h9612;
        imem[9]  = 16'h8700;  imem[10] = 16'hC002;  imem[13] = 16'hD002;
        imem[14] = 16'h9701;  imem[15] = 16'hA871;  imem[16] = 16'hB071;
        imem[20] = 16'hE005;  imem[26] = 16'hC00B;  imem[22] = 16'hF0B0;
        imem[21] = 16'hCCC7;  imem[29] = 16'hEFE0;  imem[16'hFFFE] = 16'hE029;
        imem[40] = 16'hC00F;
        dmem[16'h0101] = 16'hBEEF;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_checks = 0; n_pass = 0;
        resp_en = 0; lat_chk = 0;
        imode = 0; dmode = 0;
        instr_data_i = '0; data_data_i = '0;
        instr_ack_i = 1'b0; data_ack_i = 1'b0;
        sys_rst = 1'b1;
        load_directed();

        // Reset held with acks asserted
        #2 sys_rst = 1'b0;
        instr_ack_i = 1'b1;
        data_ack_i  = 1'b1;
        repeat (3) @(negedge sys_clk);
        chk("rst_instr_stb", instr_stb_o, 0);
        chk("rst_data_stb", data_stb_o, 0);
        chk("rst_instr_we", instr_we_o, 0);
        chk("rst_data_we", data_we_o, 0);
        chk("rst_instr_addr", instr_addr_o, 0);
        chk("rst_data_addr", data_addr_o, 0);
        chk("rst_data_data", data_data_o, 0);
        chk("rst_pc", dut.unit.pc, RESET_PC);
        for (int i = 0; i < 16; i++) chk($sformatf("rst_rf[%0d]", i), dut.u_rf.rf[i], 0);
        instr_ack_i = 1'b0;
        data_ack_i  = 1'b0;
        init_model();
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        chk("rel_instr_stb", instr_stb_o, 1);
        chk("rel_instr_addr", instr_addr_o, RESET_PC);
        chk("rel_data_stb", data_stb_o, 0);

        // Directed program, zero wait states
        lat_chk = 1;
        resp_en = 1;
        wait_fetches(30, 400);
        lat_chk = 0;
        for (int i = 0; i < 25; i++)
            chk($sformatf("seq[%0d]", i), fetch_log[i], exp_seq[i]);
        for (int i = 25; i < 30; i++)
            chk($sformatf("seq[%0d]", i), fetch_log[i], 16'd40);
        chk("r0", dut.u_rf.rf[0], 16'h0005);
        chk("r1", dut.u_rf.rf[1], 16'hFFFD);
        chk("r2", dut.u_rf.rf[2], 16'h0002);
        chk("r3", dut.u_rf.rf[3], 16'h0008);
        chk("r4", dut.u_rf.rf[4], 16'd25);
        chk("r5", dut.u_rf.rf[5], 16'h00A0);
        chk("r6", dut.u_rf.rf[6], 16'h1234);
        chk("r7", dut.u_rf.rf[7], 16'h0100);
        chk("r8", dut.u_rf.rf[8], 16'hBEEF);
        chk("r11", dut.u_rf.rf[11], 16'hFFFF);
        chk("r12", dut.u_rf.rf[12], 16'h0000);
        chk("st_cnt", st_cnt, 1);
        chk("st_addr", st_addr, 16'h0101);
        chk("st_data", st_data, 16'h0005);

        // Same program with 3-cycle waits on both ports
        dmem[16'h0101] = 16'hBEEF;
        imode = 1; dmode = 1;
        do_reset();
        wait_fetches(30, 800);
        chk("ws_r8", dut.u_rf.rf[8], 16'hBEEF);

        // Random program and data with random wait states
        for (int i = 0; i < 65536; i++) begin
            imem[i] = 16'($urandom);
            dmem[i] = 16'($urandom);
        end
        imode = 2; dmode = 2;
        do_reset();
        wait_fetches(1500, 30000);

        // Reset asserted while a store waits in MEM
        for (int i = 0; i < 4; i++) imem[i] = 16'h0CCC;
        imem[0] = 16'hB071;
        imode = 0; dmode = 3;
        do_reset();
        for (int t = 0; t < 20 && !data_stb_o; t++) @(posedge sys_clk);
        #2;
        chk("mem_stb_seen", data_stb_o, 1);
        resp_en    = 0;
        data_ack_i = 1'b1;
        sys_rst    = 1'b0;
        #1;
        chk("mrst_data_stb", data_stb_o, 0);
        chk("mrst_data_we", data_we_o, 0);
        chk("mrst_data_addr", data_addr_o, 0);
        chk("mrst_instr_stb", instr_stb_o, 0);
        @(negedge sys_clk);
        data_ack_i = 1'b0;
        sys_rst    = 1'b1;
        @(posedge sys_clk);
        #1;
        chk("mrel_instr_stb", instr_stb_o, 1);
        chk("mrel_instr_addr", instr_addr_o, RESET_PC);
        chk("mrel_data_stb", data_stb_o, 0);
        chk("mrel_pc", dut.unit.pc, RESET_PC);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/cpu_top.md
Name: cpu_top

Overview:
- Multicycle 16-bit RISC CPU core; top level of the processor.
- Separate Wishbone-style instruction and data master ports.
- 16-entry register file and a word-addressed program counter.
- Register file is exposed hierarchically as u_rf.rf[0..15]; the address of the current instruction is exposed as unit.pc_1, so the system bench can observe architectural state.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- sys_clk  in  1  single clock; all state updates on the rising edge.
- sys_rst  in  1  reset; asynchronous, active-low.
- instr_addr_o  out  16  instruction word address (the PC).
- instr_data_i  in  16  fetched instruction.
- instr_stb_o  out  1  instruction request strobe.
- instr_we_o  out  1  always 0.
- instr_ack_i  in  1  instruction transfer acknowledge.
- data_addr_o  out  16  load/store word address.
- data_data_o  out  16  store data.
- data_data_i  in  16  load data.
- data_stb_o  out  1  data request strobe.
- data_we_o  out  1  1 = store, 0 = load.
- data_ack_i  in  1  data transfer acknowledge.

Behaviour:
- Reset (sys_rst=0), asynchronous:
  - PC=RESET_PC; rf[0..15]=0; state=FETCH.
  - All outputs 0 (both stb, both we, addresses, data_data_o).
  - Reset asserted mid-transfer drops the strobe immediately; a pending ack is discarded.
- Registers:
  - rf[12] (zero) always reads 0; writes to it are ignored.
  - rf[11] (lr) is the link register.
  - All other registers are general purpose, including rf[10] (mr).
- Instruction format: op[15:12], rd[11:8], ra[7:4], rb[3:0]; imm4=[3:0]; imm8=[7:0]; imm12=[11:0]. All immediates are sign-extended unless stated.
- Opcodes (all arithmetic is 16-bit and wraps, no flags):
  - 0 ADD: rd=ra+rb
  - 1 SUB: rd=ra-rb
  - 2 AND: rd=ra&rb
  - 3 OR: rd=ra|rb
  - 4 XOR: rd=ra^rb
  - 5 SHL: rd=ra<<rb[3:0]
  - 6 SHR (logical): rd=ra>>rb[3:0]
  - 7 MUL: rd=low16(ra*rb)
  - 8 LI: rd=sext(imm8)
  - 9 LUI: rd={imm8, rd[7:0]}
  - A LD: rd=mem[ra+sext(imm4)]
  - B ST: mem[ra+sext(imm4)]=rd
  - C BEQ: if rd==ra then PC=PC+1+sext(imm4)
  - D BNE: if rd!=ra then PC=PC+1+sext(imm4)
  - E JAL: lr=PC+1; PC=PC+1+sext(imm12)
  - F JR: PC=ra
  - Canonical NOP: 16'h0CCC.
- States:
  - FETCH: instr_stb_o=1, instr_addr_o=PC. On the edge where instr_ack_i=1, latch instr_data_i, set pc_1=PC, drop stb, go to EXEC. Wait states are unbounded.
  - EXEC (1 cycle): ALU ops write rd and set PC=PC+1, then go to FETCH. Branches, JAL and JR update PC, then go to FETCH. LD/ST compute the address and go to MEM.
  - MEM: data_stb_o=1 with data_addr_o, data_we_o and data_data_o held stable until data_ack_i. On ack: LD writes rd from data_data_i; PC=PC+1; drop stb; go to FETCH.
- Latency at zero wait state: 2 cycles per non-memory instruction, 3 per LD/ST.
- Strobe rules:
  - Strobes are never asserted in EXEC.
  - An ack arriving while the corresponding stb=0 is ignored.
  - Ack in the same cycle stb rises is valid.
- PC and address arithmetic wrap modulo 2^16.
- Reading and writing the same register in one instruction uses the old value.

Test Plan:
- Reset: hold sys_rst=0 while driving ack=1 -> both stb=0, PC=0, rf all 0. Release -> instr_stb_o=1, instr_addr_o=0 on the first edge.
- ALU sequence, zero-wait memory: LI r0,5; LI r1,-3; ADD r2,r0,r1; SUB r3,r0,r1; MUL r4,r0,r0; SHL r5,r0,r0 -> r0=5, r1=FFFD, r2=2, r3=8, r4=25, r5=00A0. Each instruction takes 2 cycles.
- Zero register and LUI:
  - LI r12,7 -> rf[12] stays 0.
  - LI r6,34h then LUI r6,12h -> r6=1234.
- Branches:
  - BEQ r0,r0,+2 at PC=10 -> next fetch at 13.
  - BNE r0,r0,+2 at PC=10 -> next fetch at 11.
  - Negative offset wraps correctly.
- Link and return:
  - JAL +5 at PC=20 -> lr=21, next fetch at 26.
  - JR lr -> next fetch at 21.
- Wait states and load/store:
  - Delay instr_ack_i by 3 cycles -> instr_stb_o and instr_addr_o held stable throughout.
  - ST r0,[r7+1] with r7=100h -> data_addr_o=101h, data_we_o=1, data_data_o=5.
  - LD r8,[r7+1] returning BEEF -> r8=BEEF.
  - Reset asserted during MEM -> data_stb_o=0 immediately.
